// File: rtl/axis_i2c_target.sv
// I2C target: bus-master writes leave on m_axis_*, bus-master reads are fed from s_axis_*.
// Latency: a written byte appears on m_axis 1 clk after the 8th SCL rise is seen (sync + edge detect adds SYNC_STAGES+1 clk).
// Backpressure: m_axis byte held until tready; a new write byte arriving while tvalid is still high is NACKed and dropped.
//
// Ports:
//   clk_i, arstn_i           system clock (>= 8x SCL), synchronous active-low reset
//   i2c_scl_i, i2c_sda_i     raw pad inputs
//   i2c_sda_oe_o             1 = pull SDA low (open drain, pad owned by top level)
//   m_axis_tdata/tvalid/tready  bytes written by the bus master
//   s_axis_tdata/tvalid/tready  bytes returned to the bus master (tready is a 1-cycle pulse)
//   busy_o, stop_o           addressed-transfer flag, 1-cycle pulse on STOP ending one
module axis_i2c_target #(
    parameter int         I2C_DATA_WIDTH = 8,
    parameter logic [6:0] DEV_ADDR       = 7'h50,
    parameter int         SYNC_STAGES    = 2
) (
    input  logic                      clk_i,
    input  logic                      arstn_i,
    input  logic                      i2c_scl_i,
    input  logic                      i2c_sda_i,
    output logic                      i2c_sda_oe_o,
    output logic [I2C_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    input  logic [I2C_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    output logic                      busy_o,
    output logic                      stop_o
);
    localparam int W  = I2C_DATA_WIDTH;
    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] ADDR_LAST = CW'(7);
    localparam logic [CW-1:0] ADDR_BITS = CW'(8);
    localparam logic [CW-1:0] DATA_LAST = CW'(W - 1);
    localparam logic [CW-1:0] DATA_BITS = CW'(W);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_WAIT
    } state_t;

    // Input synchronizers plus one history flop; idle bus level is high.
    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_q, sda_q;
    logic                   scl_s, sda_s;

    always_ff @(posedge clk_i) begin
        if (!arstn_i) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], i2c_scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], i2c_sda_i};
            scl_q    <= scl_s;
            sda_q    <= sda_s;
        end
    end

    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];

    logic scl_rise, scl_fall, start_det, stop_det;
    assign scl_rise  = scl_s & ~scl_q;
    assign scl_fall  = ~scl_s & scl_q;
    assign start_det = scl_s & scl_q & sda_q & ~sda_s;
    assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;

    // Underrun returns all ones, which also leaves SDA released for the whole byte.
    logic [W-1:0] rd_byte;
    assign rd_byte = s_axis_tvalid ? s_axis_tdata : '1;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  sh_q, sh_d, m_tdata_q, m_tdata_d;
    logic          rw_q, rw_d, ack_q, ack_d, oe_q, oe_d, busy_q, busy_d;
    logic          stop_q, stop_d, m_tvalid_q, m_tvalid_d, s_tready_q, s_tready_d;

    always_ff @(posedge clk_i) begin
        if (!arstn_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            sh_q       <= '0;
            rw_q       <= 1'b0;
            ack_q      <= 1'b0;
            oe_q       <= 1'b0;
            busy_q     <= 1'b0;
            stop_q     <= 1'b0;
            m_tdata_q  <= '0;
            m_tvalid_q <= 1'b0;
            s_tready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sh_q       <= sh_d;
            rw_q       <= rw_d;
            ack_q      <= ack_d;
            oe_q       <= oe_d;
            busy_q     <= busy_d;
            stop_q     <= stop_d;
            m_tdata_q  <= m_tdata_d;
            m_tvalid_q <= m_tvalid_d;
            s_tready_q <= s_tready_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sh_d       = sh_q;
        rw_d       = rw_q;
        ack_d      = ack_q;
        oe_d       = oe_q;
        busy_d     = busy_q;
        stop_d     = 1'b0;
        m_tdata_d  = m_tdata_q;
        m_tvalid_d = m_tvalid_q;
        s_tready_d = 1'b0;

        if (m_tvalid_q && m_axis_tready) m_tvalid_d = 1'b0;

        if (start_det) begin
            state_d = S_ADDR;
            cnt_d   = '0;
            oe_d    = 1'b0;
        end else if (stop_det) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
            stop_d  = busy_q;
        end else begin
            case (state_q)
                S_ADDR: begin
                    if (scl_rise) begin
                        sh_d  = {sh_q[W-2:0], sda_s};
                        cnt_d = cnt_q + CW'(1);
                        // Before the 8th bit is shifted in, sh_q[6:0] holds the 7 address bits.
                        if (cnt_q == ADDR_LAST) begin
                            if (sh_q[6:0] == DEV_ADDR) begin
                                rw_d = sda_s;
                            end else begin
                                state_d = S_WAIT;
                                cnt_d   = '0;
                            end
                        end
                    end else if (scl_fall && cnt_q == ADDR_BITS) begin
                        oe_d    = 1'b1;
                        busy_d  = 1'b1;
                        state_d = S_ADDR_ACK;
                        cnt_d   = '0;
                    end
                end
                S_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (rw_q) begin
                            sh_d       = rd_byte;
                            oe_d       = ~rd_byte[W-1];
                            s_tready_d = s_axis_tvalid;
                            state_d    = S_RD_DATA;
                        end else begin
                            oe_d    = 1'b0;
                            state_d = S_WR_DATA;
                        end
                    end
                end
                S_WR_DATA: begin
                    if (scl_rise) begin
                        sh_d  = {sh_q[W-2:0], sda_s};
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_q == DATA_LAST) begin
                            ack_d = ~m_tvalid_q;
                            if (!m_tvalid_q) begin
                                m_tdata_d  = {sh_q[W-2:0], sda_s};
                                m_tvalid_d = 1'b1;
                            end
                        end
                    end else if (scl_fall && cnt_q == DATA_BITS) begin
                        oe_d    = ack_q;
                        state_d = S_WR_ACK;
                        cnt_d   = '0;
                    end
                end
                S_WR_ACK: begin
                    if (scl_fall) begin
                        oe_d    = 1'b0;
                        state_d = S_WR_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (scl_rise) begin
                        cnt_d = cnt_q + CW'(1);
                    end else if (scl_fall) begin
                        if (cnt_q == DATA_BITS) begin
                            oe_d    = 1'b0;
                            state_d = S_RD_ACK;
                            cnt_d   = '0;
                        end else begin
                            oe_d = ~sh_q[W-2];
                            sh_d = {sh_q[W-2:0], 1'b1};
                        end
                    end
                end
                S_RD_ACK: begin
                    // cnt_q == 1 marks "master ACKed, reload on the next falling edge".
                    if (scl_rise) begin
                        if (sda_s) state_d = S_WAIT;
                        else       cnt_d   = CW'(1);
                    end else if (scl_fall && cnt_q == CW'(1)) begin
                        sh_d       = rd_byte;
                        oe_d       = ~rd_byte[W-1];
                        s_tready_d = s_axis_tvalid;
                        state_d    = S_RD_DATA;
                        cnt_d      = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign i2c_sda_oe_o  = oe_q;
    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tvalid = m_tvalid_q;
    assign s_axis_tready = s_tready_q;
    assign busy_o        = busy_q;
    assign stop_o        = stop_q;
endmodule

// File: tb/tb_axis_i2c_target.sv
`timescale 1ns/1ps
// Bench for axis_i2c_target: a bit-banged I2C master drives the bus, expected
// responses are queued as stimulus is issued, and a monitor process compares.
module tb_axis_i2c_target;
    localparam int Q = 8;   // SCL quarter period in clk cycles (SCL = clk/32)

    logic       clk_i = 1'b0;
    logic       arstn_i = 1'b0;
    logic       scl = 1'b1;
    logic       msda = 1'b1;
    logic       m_axis_tready = 1'b0;
    logic [7:0] s_axis_tdata = 8'h00;
    logic       s_axis_tvalid = 1'b0;
    logic       sda_oe, m_axis_tvalid, s_axis_tready, busy_o, stop_o;
    logic [7:0] m_axis_tdata;
    wire        sda_bus = msda & ~sda_oe;

    always #5 clk_i = ~clk_i;

    axis_i2c_target #(.I2C_DATA_WIDTH(8), .DEV_ADDR(7'h50), .SYNC_STAGES(2)) dut (
        .clk_i(clk_i), .arstn_i(arstn_i),
        .i2c_scl_i(scl), .i2c_sda_i(sda_bus), .i2c_sda_oe_o(sda_oe),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .busy_o(busy_o), .stop_o(stop_o)
    );

    int total = 0;
    int bad = 0;

    // Scoreboard queues
    logic       exp_bit_q[$];
    logic [7:0] exp_wr_q[$];
    logic       exp_rdy_q[$];
    logic       exp_stop_q[$];
    int         probe_kind_q[$];
    logic [7:0] probe_val_q[$];
    logic       samp_stb = 1'b0;
    logic       probe_stb = 1'b0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        total++;
        bad++;
        $display("FAIL %s: event seen, none expected", name);
    endtask

    // Monitor: samples 1 ns after the falling clk edge, where stimulus has settled
    // and values hold until the next rising edge.
    initial forever begin
        @(negedge clk_i);
        #1;
        if (samp_stb) begin
            if (exp_bit_q.size() == 0) unexpected("sda_sample");
            else check("sda_bit", {7'b0, sda_bus}, {7'b0, exp_bit_q.pop_front()});
        end
        if (m_axis_tvalid && m_axis_tready) begin
            if (exp_wr_q.size() == 0) unexpected("m_axis_beat");
            else check("m_axis_tdata", m_axis_tdata, exp_wr_q.pop_front());
        end
        if (s_axis_tready) begin
            if (exp_rdy_q.size() == 0) unexpected("s_axis_tready");
            else void'(exp_rdy_q.pop_front());
        end
        if (stop_o) begin
            if (exp_stop_q.size() == 0) unexpected("stop_o");
            else void'(exp_stop_q.pop_front());
        end
        if (probe_stb) begin
            while (probe_kind_q.size() != 0) begin
                int         k;
                logic [7:0] v;
                k = probe_kind_q.pop_front();
                v = probe_val_q.pop_front();
                case (k)
                    0: check("busy_o", {7'b0, busy_o}, v);
                    1: check("sda_oe", {7'b0, sda_oe}, v);
                    2: check("m_axis_tvalid", {7'b0, m_axis_tvalid}, v);
                    3: check("m_axis_tdata_hold", m_axis_tdata, v);
                    4: check("s_axis_tready", {7'b0, s_axis_tready}, v);
                    default: check("stop_o", {7'b0, stop_o}, v);
                endcase
            end
        end
    end

    task automatic quarter();
        repeat (Q) @(negedge clk_i);
    endtask

    task automatic probe(input int kind, input logic [7:0] v);
        probe_kind_q.push_back(kind);
        probe_val_q.push_back(v);
    endtask

    task automatic fire();
        probe_stb = 1'b1;
        @(negedge clk_i);
        probe_stb = 1'b0;
    endtask

    task automatic start_cond();
        msda = 1'b1; quarter();
        scl  = 1'b1; quarter();
        msda = 1'b0; quarter();
        scl  = 1'b0; quarter();
    endtask

    task automatic stop_cond();
        msda = 1'b0; quarter();
        scl  = 1'b1; quarter();
        msda = 1'b1; quarter();
    endtask

    // One SCL clock: master drives b, the resolved bus is expected to read e mid-high.
    task automatic clock_bit(input logic b, input logic e);
        msda = b; quarter();
        scl  = 1'b1; quarter();
        exp_bit_q.push_back(e);
        samp_stb = 1'b1;
        @(negedge clk_i);
        samp_stb = 1'b0;
        quarter();
        scl = 1'b0; quarter();
    endtask

    task automatic write_byte(input logic [7:0] d, input logic ack);
        for (int i = 7; i >= 0; i--) clock_bit(d[i], d[i]);
        clock_bit(1'b1, ~ack);
    endtask

    task automatic read_byte(input logic [7:0] e, input logic master_ack);
        for (int i = 7; i >= 0; i--) clock_bit(1'b1, e[i]);
        clock_bit(~master_ack, ~master_ack);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (5) @(negedge clk_i);
        probe(0, 8'h0); probe(1, 8'h0); probe(2, 8'h0); probe(4, 8'h0); probe(5, 8'h0);
        fire();
        arstn_i = 1'b1;
        quarter();

        // Write A0, 3C with tready high
        m_axis_tready = 1'b1;
        start_cond();
        write_byte(8'hA0, 1'b1);
        probe(0, 8'h1); fire();
        exp_wr_q.push_back(8'h3C);
        write_byte(8'h3C, 1'b1);
        exp_stop_q.push_back(1'b1);
        stop_cond();
        probe(0, 8'h0); fire();
        quarter();

        // Read 96 with master NACK
        s_axis_tdata  = 8'h96;
        s_axis_tvalid = 1'b1;
        start_cond();
        exp_rdy_q.push_back(1'b1);
        write_byte(8'hA1, 1'b1);
        read_byte(8'h96, 1'b0);
        s_axis_tvalid = 1'b0;
        exp_stop_q.push_back(1'b1);
        stop_cond();
        quarter();

        // Address 0x42 mismatch: everything NACKed, no side effects
        start_cond();
        write_byte(8'h84, 1'b0);
        write_byte(8'h55, 1'b0);
        probe(0, 8'h0); probe(1, 8'h0); fire();
        stop_cond();
        quarter();

        // Backpressure: second data byte overflows
        m_axis_tready = 1'b0;
        start_cond();
        write_byte(8'hA0, 1'b1);
        write_byte(8'h11, 1'b1);
        write_byte(8'h22, 1'b0);
        exp_stop_q.push_back(1'b1);
        stop_cond();
        probe(2, 8'h1); probe(3, 8'h11); fire();
        exp_wr_q.push_back(8'h11);
        m_axis_tready = 1'b1;
        repeat (3) @(negedge clk_i);
        probe(2, 8'h0); fire();
        quarter();

        // Repeated start into an underrun read
        start_cond();
        write_byte(8'hA0, 1'b1);
        exp_wr_q.push_back(8'h01);
        write_byte(8'h01, 1'b1);
        start_cond();
        probe(0, 8'h1); fire();
        write_byte(8'hA1, 1'b1);
        read_byte(8'hFF, 1'b0);
        exp_stop_q.push_back(1'b1);
        stop_cond();
        quarter();

        // Reset while the target pulls SDA low for bit 6 of 0x96
        s_axis_tdata  = 8'h96;
        s_axis_tvalid = 1'b1;
        start_cond();
        exp_rdy_q.push_back(1'b1);
        write_byte(8'hA1, 1'b1);
        clock_bit(1'b1, 1'b1);
        probe(1, 8'h1); fire();
        arstn_i = 1'b0;
        @(negedge clk_i);
        probe(1, 8'h0); probe(0, 8'h0); fire();
        s_axis_tvalid = 1'b0;
        scl  = 1'b1;
        msda = 1'b1;
        repeat (3) @(negedge clk_i);
        arstn_i = 1'b1;
        quarter();
        start_cond();
        write_byte(8'hA0, 1'b1);
        exp_wr_q.push_back(8'h5A);
        write_byte(8'h5A, 1'b1);
        exp_stop_q.push_back(1'b1);
        stop_cond();
        quarter();

        // Every queued expectation must have been consumed
        check("m_axis_left", 8'(exp_wr_q.size()), 8'h0);
        check("s_tready_left", 8'(exp_rdy_q.size()), 8'h0);
        check("stop_left", 8'(exp_stop_q.size()), 8'h0);
        check("sda_bits_left", 8'(exp_bit_q.size()), 8'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
